// File: rtl/usr_pkg.sv
// Shared mode encoding for the universal shift register and its benches.
package usr_pkg;

  localparam logic [2:0] MODE_HOLD = 3'b000;
  localparam logic [2:0] MODE_SHR  = 3'b001;
  localparam logic [2:0] MODE_SHL  = 3'b010;
  localparam logic [2:0] MODE_LOAD = 3'b011;
  localparam logic [2:0] MODE_ROTR = 3'b100;
  localparam logic [2:0] MODE_ROTL = 3'b101;
  localparam logic [2:0] MODE_ASR  = 3'b110;
  localparam logic [2:0] MODE_CLR  = 3'b111;

  // Only the two serial shifts advance the word counter.
  function automatic logic is_serial_shift(input logic [2:0] mode);
    return (mode == MODE_SHR) || (mode == MODE_SHL);
  endfunction

endpackage

// File: rtl/usr_bit_slice.sv
// One register bit: 8-way mode mux feeding a flop; all neighbour taps arrive pre-wired.
module usr_bit_slice
  import usr_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n_i,
  input  logic       en_i,
  input  logic [2:0] mode_i,
  input  logic       shr_src_i,
  input  logic       shl_src_i,
  input  logic       load_src_i,
  input  logic       rotr_src_i,
  input  logic       rotl_src_i,
  input  logic       asr_src_i,
  output logic       q_o
);

  logic bit_q;
  logic bit_d;

  always_comb begin
    bit_d = bit_q;
    case (mode_i)
      MODE_HOLD: bit_d = bit_q;
      MODE_SHR:  bit_d = shr_src_i;
      MODE_SHL:  bit_d = shl_src_i;
      MODE_LOAD: bit_d = load_src_i;
      MODE_ROTR: bit_d = rotr_src_i;
      MODE_ROTL: bit_d = rotl_src_i;
      MODE_ASR:  bit_d = asr_src_i;
      MODE_CLR:  bit_d = 1'b0;
      default:   bit_d = bit_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n_i) begin
      bit_q <= 1'b0;
    end else if (en_i) begin
      bit_q <= bit_d;
    end
  end

  assign q_o = bit_q;

endmodule

// File: rtl/univ_shift_reg_n.sv
// Universal N-bit shift register with a serial-word counter and one-cycle word_valid pulse.
module univ_shift_reg_n
  import usr_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic             ser_in_sl,
  input  logic             ser_in_sr,
  input  logic [WIDTH-1:0] par_in,
  output logic [WIDTH-1:0] par_out,
  output logic             ser_out_r,
  output logic             ser_out_l,
  output logic             word_valid,
  output logic [CNT_W-1:0] bit_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WIDTH - 1);

  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] shr_src;
  logic [WIDTH-1:0] shl_src;
  logic [WIDTH-1:0] rotr_src;
  logic [WIDTH-1:0] rotl_src;
  logic [WIDTH-1:0] asr_src;

  // Candidate next values for every bit, formed as whole words so edge bits need no special case.
  assign shr_src  = {ser_in_sr, data_q[WIDTH-1:1]};
  assign shl_src  = {data_q[WIDTH-2:0], ser_in_sl};
  assign rotr_src = {data_q[0], data_q[WIDTH-1:1]};
  assign rotl_src = {data_q[WIDTH-2:0], data_q[WIDTH-1]};
  assign asr_src  = {data_q[WIDTH-1], data_q[WIDTH-1:1]};

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_slice
      usr_bit_slice u_slice (
        .clk        (clk),
        .rst_n_i    (rst_n),
        .en_i       (en),
        .mode_i     (mode),
        .shr_src_i  (shr_src[gi]),
        .shl_src_i  (shl_src[gi]),
        .load_src_i (par_in[gi]),
        .rotr_src_i (rotr_src[gi]),
        .rotl_src_i (rotl_src[gi]),
        .asr_src_i  (asr_src[gi]),
        .q_o        (data_q[gi])
      );
    end
  endgenerate

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             wv_q;
  logic             wv_d;

  always_comb begin
    cnt_d = cnt_q;
    wv_d  = 1'b0;
    if (en) begin
      if (is_serial_shift(mode)) begin
        if (cnt_q == CNT_MAX) begin
          cnt_d = '0;
          wv_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end else if ((mode == MODE_LOAD) || (mode == MODE_CLR)) begin
        cnt_d = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
      wv_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      wv_q  <= wv_d;
    end
  end

  assign par_out    = data_q;
  assign ser_out_r  = data_q[0];
  assign ser_out_l  = data_q[WIDTH-1];
  assign word_valid = wv_q;
  assign bit_cnt    = cnt_q;

endmodule

// File: tb/tb_univ_shift_reg_n.sv
// Directed bench for univ_shift_reg_n (WIDTH=8) with a reference model feeding a scoreboard queue.
module tb_univ_shift_reg_n;
  import usr_pkg::*;

  localparam int W  = 8;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          en;
  logic [2:0]    mode;
  logic          ser_in_sl;
  logic          ser_in_sr;
  logic [W-1:0]  par_in;
  logic [W-1:0]  par_out;
  logic          ser_out_r;
  logic          ser_out_l;
  logic          word_valid;
  logic [CW-1:0] bit_cnt;

  univ_shift_reg_n #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .mode       (mode),
    .ser_in_sl  (ser_in_sl),
    .ser_in_sr  (ser_in_sr),
    .par_in     (par_in),
    .par_out    (par_out),
    .ser_out_r  (ser_out_r),
    .ser_out_l  (ser_out_l),
    .word_valid (word_valid),
    .bit_cnt    (bit_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0]  par;
    logic [CW-1:0] cnt;
    logic          wv;
  } exp_t;

  exp_t          sb[$];
  int            checks = 0;
  int            errors = 0;
  int            cyc = 0;
  int            pulses = 0;
  int            pulse_cyc[$];
  logic [W-1:0]  m_par = '0;
  logic [CW-1:0] m_cnt = '0;
  logic          m_wv = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle, predict its outcome into the scoreboard, then compare after the edge.
  task automatic step(input string tag, input logic r, input logic e, input logic [2:0] m,
                      input logic sl, input logic sr, input logic [W-1:0] pi);
    exp_t x;
    exp_t got;
    rst_n = r; en = e; mode = m; ser_in_sl = sl; ser_in_sr = sr; par_in = pi;
    if (!r) begin
      m_par = '0; m_cnt = '0; m_wv = 1'b0;
    end else if (!e) begin
      m_wv = 1'b0;
    end else begin
      m_wv = 1'b0;
      case (m)
        MODE_SHR:  m_par = (m_par >> 1) | (W'(sr) << (W - 1));
        MODE_SHL:  m_par = (m_par << 1) | W'(sl);
        MODE_LOAD: m_par = pi;
        MODE_ROTR: m_par = (m_par >> 1) | (W'(m_par[0]) << (W - 1));
        MODE_ROTL: m_par = (m_par << 1) | W'(m_par[W-1]);
        MODE_ASR:  m_par = (m_par >> 1) | (m_par & 8'h80);
        MODE_CLR:  m_par = '0;
        default:   m_par = m_par;
      endcase
      if (m == MODE_SHR || m == MODE_SHL) begin
        if (m_cnt == CW'(W - 1)) begin
          m_cnt = '0; m_wv = 1'b1;
        end else begin
          m_cnt = m_cnt + 1'b1;
        end
      end else if (m == MODE_LOAD || m == MODE_CLR) begin
        m_cnt = '0;
      end
    end
    x.par = m_par; x.cnt = m_cnt; x.wv = m_wv;
    sb.push_back(x);
    @(posedge clk);
    #1;
    cyc++;
    if (sb.size() == 0) begin
      chk({tag, ".sb_empty"}, 64'd1, 64'd0);
    end else begin
      got = sb.pop_front();
      chk({tag, ".par_out"}, 64'(par_out), 64'(got.par));
      chk({tag, ".bit_cnt"}, 64'(bit_cnt), 64'(got.cnt));
      chk({tag, ".word_valid"}, 64'(word_valid), 64'(got.wv));
      chk({tag, ".ser_out_r"}, 64'(ser_out_r), 64'(got.par[0]));
      chk({tag, ".ser_out_l"}, 64'(ser_out_l), 64'(got.par[W-1]));
    end
    if (word_valid === 1'b1) begin
      pulses++;
      pulse_cyc.push_back(cyc);
    end
    $display("step %-10s mode=%0d en=%0b rst_n=%0b par_out=%02h bit_cnt=%0d word_valid=%0b",
             tag, m, e, r, par_out, bit_cnt, word_valid);
  endtask

  initial begin
    logic [W-1:0] stream;
    stream = 8'b1011_0010;
    rst_n = 1'b0; en = 1'b0; mode = MODE_HOLD; ser_in_sl = 1'b0; ser_in_sr = 1'b0; par_in = '0;

    // Reset wins over en/mode.
    step("reset", 1'b0, 1'b1, MODE_LOAD, 1'b0, 1'b0, 8'hFF);
    step("reset2", 1'b0, 1'b0, MODE_HOLD, 1'b0, 1'b0, 8'h00);
    chk("reset.par", 64'(par_out), 64'h00);

    step("load_a5", 1'b1, 1'b1, MODE_LOAD, 1'b0, 1'b0, 8'hA5);
    chk("load.par", 64'(par_out), 64'hA5);
    step("shl", 1'b1, 1'b1, MODE_SHL, 1'b1, 1'b0, 8'h00);
    chk("shl.par", 64'(par_out), 64'h4B);
    step("shr", 1'b1, 1'b1, MODE_SHR, 1'b0, 1'b0, 8'h00);
    chk("shr.par", 64'(par_out), 64'h25);
    step("asr_hold", 1'b1, 1'b1, MODE_ASR, 1'b0, 1'b0, 8'h00);
    step("load_85", 1'b1, 1'b1, MODE_LOAD, 1'b0, 1'b0, 8'h85);
    step("asr", 1'b1, 1'b1, MODE_ASR, 1'b0, 1'b0, 8'h00);
    chk("asr.par", 64'(par_out), 64'hC2);
    step("load_81", 1'b1, 1'b1, MODE_LOAD, 1'b0, 1'b0, 8'h81);
    step("rotr", 1'b1, 1'b1, MODE_ROTR, 1'b1, 1'b1, 8'h00);
    chk("rotr.par", 64'(par_out), 64'hC0);
    step("load_81b", 1'b1, 1'b1, MODE_LOAD, 1'b0, 1'b0, 8'h81);
    step("rotl", 1'b1, 1'b1, MODE_ROTL, 1'b0, 1'b0, 8'h00);
    chk("rotl.par", 64'(par_out), 64'h03);

    // Eight SHR with a serial stream forms one word.
    step("clr", 1'b1, 1'b1, MODE_CLR, 1'b0, 1'b0, 8'h00);
    pulses = 0;
    for (int i = 0; i < 8; i++) step("shr_word", 1'b1, 1'b1, MODE_SHR, 1'b0, stream[7-i], 8'h00);
    chk("word.par", 64'(par_out), 64'h4D);
    chk("word.wv", 64'(word_valid), 64'd1);
    chk("word.cnt", 64'(bit_cnt), 64'd0);
    step("after_word", 1'b1, 1'b1, MODE_HOLD, 1'b0, 1'b0, 8'h00);
    chk("word.pulses", 64'(pulses), 64'd1);

    // Clock-enable gap in the middle of a word.
    step("load_gap", 1'b1, 1'b1, MODE_LOAD, 1'b0, 1'b0, 8'h3C);
    pulses = 0;
    for (int i = 0; i < 5; i++) step("shl5", 1'b1, 1'b1, MODE_SHL, 1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 3; i++) step("en_off", 1'b1, 1'b0, MODE_CLR, 1'b1, 1'b1, 8'hFF);
    chk("gap.cnt", 64'(bit_cnt), 64'd5);
    for (int i = 0; i < 3; i++) step("shl3", 1'b1, 1'b1, MODE_SHL, 1'b0, 1'b0, 8'h00);
    step("gap_post", 1'b1, 1'b1, MODE_ROTL, 1'b0, 1'b0, 8'h00);
    chk("gap.pulses", 64'(pulses), 64'd1);

    // LOAD mid-word restarts the count.
    pulses = 0;
    for (int i = 0; i < 6; i++) step("pre6", 1'b1, 1'b1, (i % 2 == 0) ? MODE_SHR : MODE_SHL, 1'b1, 1'b0, 8'h00);
    step("reload", 1'b1, 1'b1, MODE_LOAD, 1'b0, 1'b0, 8'h96);
    for (int i = 0; i < 7; i++) step("post7", 1'b1, 1'b1, MODE_SHR, 1'b0, 1'b1, 8'h00);
    chk("reload.nopulse", 64'(pulses), 64'd0);
    step("post8", 1'b1, 1'b1, MODE_SHR, 1'b0, 1'b1, 8'h00);
    chk("reload.pulses", 64'(pulses), 64'd1);

    // Reset discards a partial word.
    step("load_ff", 1'b1, 1'b1, MODE_LOAD, 1'b0, 1'b0, 8'hFF);
    for (int i = 0; i < 4; i++) step("ff_shift", 1'b1, 1'b1, MODE_SHL, 1'b0, 1'b0, 8'h00);
    step("mid_reset", 1'b0, 1'b1, MODE_SHL, 1'b0, 1'b0, 8'h00);
    chk("midrst.par", 64'(par_out), 64'h00);
    chk("midrst.cnt", 64'(bit_cnt), 64'd0);
    pulses = 0;
    for (int i = 0; i < 8; i++) step("rst_word", 1'b1, 1'b1, MODE_SHL, 1'b1, 1'b0, 8'h00);
    step("rst_post", 1'b1, 1'b1, MODE_HOLD, 1'b0, 1'b0, 8'h00);
    chk("midrst.pulses", 64'(pulses), 64'd1);

    // Back-to-back words: two pulses exactly W cycles apart.
    pulses = 0;
    pulse_cyc.delete();
    for (int i = 0; i < 16; i++) step("b2b", 1'b1, 1'b1, MODE_SHR, 1'b0, i[0], 8'h00);
    chk("b2b.pulses", 64'(pulses), 64'd2);
    if (pulse_cyc.size() == 2) chk("b2b.spacing", 64'(pulse_cyc[1] - pulse_cyc[0]), 64'(W));
    else chk("b2b.pulse_list", 64'(pulse_cyc.size()), 64'd2);

    // CLR overrides a pending wrap.
    for (int i = 0; i < 7; i++) step("pre_clr", 1'b1, 1'b1, MODE_SHL, 1'b1, 1'b0, 8'h00);
    step("asr_keep", 1'b1, 1'b1, MODE_ASR, 1'b0, 1'b0, 8'h00);
    chk("asr.cnt", 64'(bit_cnt), 64'd7);
    step("clr_wrap", 1'b1, 1'b1, MODE_CLR, 1'b0, 1'b0, 8'h00);
    chk("clr.wv", 64'(word_valid), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/univ_shift_reg_n.md
UNIV_SHIFT_REG_N -- requirements
Module: univ_shift_reg_n

Interface
REQ-001 Parameter WIDTH, default 8, register width in bits; legal range 2..64.
REQ-002 Parameter CNT_W, default $clog2(WIDTH+1), width of bit_cnt; derived, not overridden.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 en  input  1  clock enable; 0 freezes all state.
REQ-006 mode  input  3  operation select; encoding per REQ-012.
REQ-007 ser_in_sl  input  1  serial bit entering bit 0 on shift-left.
REQ-008 ser_in_sr  input  1  serial bit entering bit WIDTH-1 on shift-right.
REQ-009 par_in  input  WIDTH  parallel load data.
REQ-010 par_out  output  WIDTH  register contents, registered.
REQ-011 ser_out_r / ser_out_l  output  1 each  par_out[0] / par_out[WIDTH-1], combinational taps.
REQ-011a word_valid  output  1  one-cycle pulse: WIDTH serial shifts completed.
REQ-011b bit_cnt  output  CNT_W  shifts accumulated since last load/clear/wrap.

Function
REQ-012 mode encoding, applied on rising edge when en=1:
- 000 HOLD: par_out unchanged.
- 001 SHR: par_out <= {ser_in_sr, par_out[WIDTH-1:1]}.
- 010 SHL: par_out <= {par_out[WIDTH-2:0], ser_in_sl}.
- 011 LOAD: par_out <= par_in.
- 100 ROTR: par_out <= {par_out[0], par_out[WIDTH-1:1]}.
- 101 ROTL: par_out <= {par_out[WIDTH-2:0], par_out[WIDTH-1]}.
- 110 ASR: par_out <= {par_out[WIDTH-1], par_out[WIDTH-1:1]}.
- 111 CLR: par_out <= 0.
REQ-013 Latency: new par_out visible one cycle after the sampling edge; ser_out_* follow par_out with zero added delay.
REQ-014 en=0: par_out, bit_cnt held; word_valid driven 0 on next edge.
REQ-015 bit_cnt increments by 1 on each enabled SHR or SHL; direction mixing is permitted and counted.
REQ-016 When an enabled SHR/SHL occurs with bit_cnt = WIDTH-1: bit_cnt wraps to 0 and word_valid = 1 for the following cycle only.
REQ-017 LOAD and CLR set bit_cnt to 0 and word_valid to 0, overriding any pending wrap.
REQ-018 HOLD, ROTR, ROTL, ASR leave bit_cnt unchanged; word_valid = 0 after them.
REQ-019 Back-to-back wraps (2*WIDTH consecutive shifts) produce two word_valid pulses exactly WIDTH cycles apart.
REQ-020 bit_cnt never exceeds WIDTH-1.
REQ-021 Unknown/X mode is not a legal input; no recovery behaviour is required.

Reset
REQ-022 rst_n=0 sampled on a rising edge: par_out = 0, bit_cnt = 0, word_valid = 0; reset takes priority over en and mode.
REQ-023 Reset mid-shift-sequence discards the partial count; the first shift after release counts as shift 1.
REQ-024 No output is asynchronously affected by rst_n.

Structure
REQ-025 Package usr_pkg holds the mode encoding as named constants (MODE_HOLD ... MODE_CLR) shared with benches.
REQ-026 One sub-module usr_bit_slice: per-bit 8-input mode mux plus flop, instantiated WIDTH times via generate; neighbour/serial/sign inputs wired at top.
REQ-027 Counter and word_valid logic reside in the top module.

Verification (WIDTH=8)
REQ-028 Reset then LOAD par_in=8'hA5 -> par_out=8'hA5 next cycle, bit_cnt=0.
REQ-029 From 8'hA5: SHL with ser_in_sl=1 -> 8'h4B; SHR with ser_in_sr=0 -> 8'h25; ASR on 8'h85 -> 8'hC2; ROTR on 8'h81 -> 8'hC0; ROTL on 8'h81 -> 8'h03.
REQ-030 8 consecutive SHR with ser_in_sr stream 1,0,1,1,0,0,1,0 -> par_out=8'h4D, word_valid high exactly one cycle after 8th edge, bit_cnt=0.
REQ-031 5 SHL, en=0 for 3 cycles, 3 more SHL -> word_valid pulses once, after the 8th shift; state frozen during en=0.
REQ-032 6 shifts then LOAD, then 8 shifts -> word_valid only after the 8 post-load shifts.
REQ-033 rst_n=0 asserted after 4 shifts of 8'hFF content -> par_out=0, bit_cnt=0 next edge; 8 subsequent shifts -> single word_valid.
